instr_fetch: RTL
================

# instr_fetch

Instruction-fetch stage with IF/ID pipeline register for the MIPS datapath. It holds the PC and issues word fetches to instruction memory over a req/ready handshake. It latches the returned word into the IF/ID register and drives the 6-bit opcode field straight into the control unit. Hazard-unit stalls and taken-branch redirects act on this stage, and redirects flush it.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; equals the address register, bits [1:0] always 0
- imem_ready  in  1  memory accepts request and returns data in the same cycle; sampled only while imem_req=1
- imem_rdata  in  32  instruction word; valid only when imem_req && imem_ready
- stall  in  1  hold IF/ID and PC (hazard unit)
- branch_taken  in  1  one-cycle redirect pulse
- branch_target  in  32  redirect address; bits [1:0] forced to 0 internally
- if_id_valid  out  1  IF/ID holds a live instruction
- if_id_instr  out  32  latched instruction
- if_id_pc4  out  32  address of latched instruction + 4
- opcode  out  6  if_id_instr[31:26], combinational, to control unit

## Operation
- Reset (async, rst_n=0): pc=PC_RESET, state=FETCH, imem_req=0 for the whole reset, if_id_valid=0, if_id_instr=0, if_id_pc4=0, opcode=0, buffer cleared.
- imem_req = (state==FETCH || state==DRAIN) && rst_n. imem_addr = pc in FETCH and the stored in-flight address in DRAIN. Address stays stable until imem_ready is seen.
- FETCH, imem_ready=1, stall=0, no branch: IF/ID gets {valid=1, instr=imem_rdata, pc4=pc+4}. pc <= pc+4. State stays FETCH.
- FETCH, imem_ready=1, stall=1: the word and pc+4 go into the hold buffer. IF/ID is held. pc <= pc+4. State goes to HOLD.
- FETCH, imem_ready=0: pc is held. IF/ID is held if stall=1, otherwise if_id_valid <= 0 (bubble).
- HOLD: imem_req=0. While stall=1, everything is held. When stall=0, IF/ID gets the buffer with valid=1 and state goes to FETCH.
- DRAIN: the request at the old address is still outstanding and must complete. When imem_ready=1, the data is discarded, pc <= saved target and state goes to FETCH. While DRAIN is active, if_id_valid=0.
- branch_taken has priority over stall and over data capture. It always forces if_id_valid <= 0 and replaces the saved target with branch_target & ~3.
  - FETCH with imem_ready=1: data discarded, pc <= target, stay FETCH.
  - FETCH with imem_ready=0: enter DRAIN and save the target.
  - HOLD: buffer discarded, pc <= target, go to FETCH.
  - DRAIN: saved target is overwritten with the newest target.
- With stall=1 and no branch, IF/ID (valid, instr, pc4) is never modified.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.

## Timing
- Fetch-to-decode latency: a word accepted at edge N (req && ready) shows on if_id_instr/opcode after edge N, within that same clock cycle.
- Throughput: 1 instruction/cycle with imem_ready held high and stall=0.
- Branch penalty with ready=1: branch_taken at edge N means the fetch from the target is requested in cycle N+1 and is valid in IF/ID after edge N+1.
- Stall release: the buffered word appears in IF/ID one edge after stall falls. The next request is issued in the cycle after that edge.
- Reset release: imem_req rises in the first cycle with rst_n=1, at addr PC_RESET.
- Reset mid-operation (any state, including DRAIN): takes effect immediately, abandons the outstanding request and returns everything to reset values.

## Test plan
- Reset then imem_ready=1 continuously, PC_RESET=0: imem_addr 0,4,8,12 in consecutive cycles; if_id_pc4 4,8,12; opcode tracks imem_rdata[31:26] (e.g. 32'h8C..._... gives 6'b100011).
- imem_ready low for 3 cycles on addr 8: imem_addr stays 8, if_id_valid=0 for those cycles, and the word is captured on the ready cycle with pc4=12.
- stall=1 for 2 cycles while a word at addr 4 is returned: IF/ID keeps the addr-0 word, imem_req=0 in HOLD, and the addr-4 word (pc4=8) appears one edge after stall falls.
- branch_taken with target 32'h0000_0103 while imem_ready=0 at addr 20: addr stays 20 until ready, that data is dropped, the next request goes to 32'h100 and if_id_valid=0 throughout.
- branch_taken and stall both high in HOLD: IF/ID is flushed (valid=0), the buffer is dropped and the next request goes to the target.
- PC at 32'hFFFF_FFFC with ready=1 wraps to 0 and pc4=0; asserting rst_n=0 mid-DRAIN drops imem_req and valid immediately and restarts at PC_RESET.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch port: a request/ready handshake.
// Memory accepts the request and returns the word in the same cycle.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   // Fetch stage side: issues requests and consumes returned words.
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   // Memory side: accepts requests and supplies words.
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch.sv
// MIPS instruction-fetch stage with IF/ID pipeline register.
// FETCH issues one word request per cycle.
// HOLD parks a word that arrived during a hazard stall.
// DRAIN waits out a request that a branch made stale, then jumps to the target.
module instr_fetch #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_if.master      imem,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [31:0]        branch_target,
   output logic               if_id_valid,
   output logic [31:0]        if_id_instr,
   output logic [31:0]        if_id_pc4,
   output logic [5:0]         opcode
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetchState_t;

   fetchState_t state, nextState;

   // While in DRAIN, pc still holds the address of the outstanding request.
   logic [31:0] pc, pcNext;
   logic [31:0] savedTarget, targetNext;
   logic [31:0] bufInstr, bufPc4;
   logic        bufLoad;
   logic        validNext;
   logic [31:0] instrNext, pc4Next;

   logic [31:0] pcPlus4;
   logic [31:0] brTarget;
   logic [31:0] drainTarget;

   // Wraps modulo 2^32 with no carry out.
   assign pcPlus4  = pc + 32'd4;
   assign brTarget = branch_target & ~32'd3;

   // A branch arriving during DRAIN supersedes the target saved earlier.
   assign drainTarget = branch_taken ? brTarget : savedTarget;

   // Gating with rst_n drops the request as soon as reset asserts, before any edge.
   assign imem.imem_req  = ((state == FETCH) || (state == DRAIN)) && rst_n;
   assign imem.imem_addr = pc;

   assign opcode = if_id_instr[31:26];

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= nextState;
      end
   end

   // Next-state, PC, IF/ID and hold-buffer decisions; a branch beats stall and capture.
   always_comb begin
      nextState  = state;
      pcNext     = pc;
      targetNext = savedTarget;
      validNext  = if_id_valid;
      instrNext  = if_id_instr;
      pc4Next    = if_id_pc4;
      bufLoad    = 1'b0;

      unique case (state)
         FETCH: begin
            if (branch_taken) begin
               validNext  = 1'b0;
               targetNext = brTarget;
               if (imem.imem_ready) begin
                  pcNext = brTarget;
               end else begin
                  nextState = DRAIN;
               end
            end else if (imem.imem_ready) begin
               pcNext = pcPlus4;
               if (stall) begin
                  bufLoad   = 1'b1;
                  nextState = HOLD;
               end else begin
                  validNext = 1'b1;
                  instrNext = imem.imem_rdata;
                  pc4Next   = pcPlus4;
               end
            end else if (!stall) begin
               validNext = 1'b0;
            end
         end

         HOLD: begin
            if (branch_taken) begin
               validNext  = 1'b0;
               targetNext = brTarget;
               pcNext     = brTarget;
               nextState  = FETCH;
            end else if (!stall) begin
               validNext = 1'b1;
               instrNext = bufInstr;
               pc4Next   = bufPc4;
               nextState = FETCH;
            end
         end

         DRAIN: begin
            validNext  = 1'b0;
            targetNext = drainTarget;
            if (imem.imem_ready) begin
               pcNext    = drainTarget;
               nextState = FETCH;
            end
         end

         default: begin
            nextState = FETCH;
         end
      endcase
   end

   // PC, saved branch target and IF/ID register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= PC_RESET;
         savedTarget <= PC_RESET;
         if_id_valid <= 1'b0;
         if_id_instr <= 32'd0;
         if_id_pc4   <= 32'd0;
      end else begin
         pc          <= pcNext;
         savedTarget <= targetNext;
         if_id_valid <= validNext;
         if_id_instr <= instrNext;
         if_id_pc4   <= pc4Next;
      end
   end

   // Hold buffer: captures the word fetched while the hazard unit stalls decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bufInstr <= 32'd0;
         bufPc4   <= 32'd0;
      end else if (bufLoad) begin
         bufInstr <= imem.imem_rdata;
         bufPc4   <= pcPlus4;
      end
   end

endmodule
